// File: rtl/note_player.sv
// note_player: plays one latched note as a square wave on sound, then an optional silent gap.
module note_player #(
    parameter int TPM_W  = 16,
    parameter int GAP_MS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [TPM_W-1:0] ticks_per_milli,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [3:0]       note_pitch,
    input  logic [1:0]       note_octave,
    input  logic [11:0]      note_ms,
    output logic             sound,
    output logic [7:0]       led,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    localparam logic [11:0] GAP_LD = 12'(GAP_MS);
    localparam logic [7:0] HP_TAB [16] = '{
        8'd0,   8'd239, 8'd225, 8'd213, 8'd201, 8'd190, 8'd179, 8'd169,
        8'd159, 8'd150, 8'd142, 8'd134, 8'd127, 8'd0,   8'd0,   8'd0
    };

    state_t           r_state;
    logic [3:0]       r_pitch;
    logic [1:0]       r_oct;
    logic [TPM_W-1:0] r_tpm;
    logic [TPM_W-1:0] r_pre;
    logic [11:0]      r_dur;
    logic [7:0]       r_hp_cnt;
    logic             r_sound;
    logic             r_done;
    logic             r_ready;

    logic             w_accept;
    logic [TPM_W-1:0] w_tpm_in;
    logic             w_ms_tick;
    logic             w_last_ms;
    logic             w_tone;
    logic [7:0]       w_hp;
    logic             w_hp_end;

    assign w_accept  = note_valid && r_ready;
    assign w_tpm_in  = (ticks_per_milli == '0) ? TPM_W'(1) : ticks_per_milli;
    assign w_ms_tick = (r_pre == r_tpm - TPM_W'(1));
    assign w_last_ms = w_ms_tick && (r_dur == 12'd1);
    assign w_tone    = (r_pitch != 4'd0) && (r_pitch <= 4'd12);
    assign w_hp      = HP_TAB[r_pitch] >> r_oct;
    assign w_hp_end  = (r_hp_cnt == w_hp - 8'd1);

    assign note_ready = r_ready;
    assign sound      = r_sound;
    assign done       = r_done;
    assign led        = (r_state == IDLE) ? 8'h00 : {1'b1, r_sound, r_oct, r_pitch};

    // Note sequencer: accept/latch, ms prescaler, duration countdown and tone generation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_pitch  <= '0;
            r_oct    <= '0;
            r_tpm    <= '0;
            r_pre    <= '0;
            r_dur    <= '0;
            r_hp_cnt <= '0;
            r_sound  <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_done <= 1'b0;
            r_pre  <= w_ms_tick ? '0 : r_pre + TPM_W'(1);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_pitch  <= note_pitch;
                        r_oct    <= note_octave;
                        r_tpm    <= w_tpm_in;
                        r_pre    <= '0;
                        r_hp_cnt <= '0;
                        r_sound  <= 1'b0;
                        if (note_ms != 12'd0) begin
                            r_state <= PLAY;
                            r_dur   <= note_ms;
                            r_ready <= 1'b0;
                        end else if (GAP_LD != 12'd0) begin
                            r_state <= GAP;
                            r_dur   <= GAP_LD;
                            r_ready <= 1'b0;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (w_ms_tick) r_dur <= r_dur - 12'd1;
                    if (w_tone) begin
                        r_hp_cnt <= w_hp_end ? 8'd0 : r_hp_cnt + 8'd1;
                        if (w_hp_end) r_sound <= ~r_sound;
                    end
                    if (w_last_ms) begin
                        r_sound <= 1'b0;
                        r_pre   <= '0;
                        if (GAP_LD != 12'd0) begin
                            r_state <= GAP;
                            r_dur   <= GAP_LD;
                        end else begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                            r_ready <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (w_ms_tick) r_dur <= r_dur - 12'd1;
                    if (w_last_ms) begin
                        r_state <= IDLE;
                        r_pre   <= '0;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_sound <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
